// File: rtl/control_fsm.sv
// Multi-cycle control unit ahead of the 8-bit ALU: fetches one instruction byte,
// decodes it, sequences the ALU and register file, and owns the PC, zero flag and HALT.
module control_fsm #(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] instr_in,
  input  logic       instr_valid,
  input  logic       zero_in,
  input  logic [7:0] jump_target,
  output logic       fetch_req,
  output logic [7:0] pc_out,
  output logic [1:0] rd_addr,
  output logic [1:0] rs_addr,
  output logic [1:0] alu_op,
  output logic       imm_sel,
  output logic [1:0] imm2,
  output logic       reg_we,
  output logic       z_flag,
  output logic       halted
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_HALT
  } state_t;

  localparam logic [3:0] OP_ADD   = 4'h0;
  localparam logic [3:0] OP_SUB   = 4'h1;
  localparam logic [3:0] OP_NAND  = 4'h2;
  localparam logic [3:0] OP_ADDI  = 4'h3;
  localparam logic [3:0] OP_SUBI  = 4'h4;
  localparam logic [3:0] OP_NANDI = 4'h5;
  localparam logic [3:0] OP_CMP   = 4'h6;
  localparam logic [3:0] OP_BZ    = 4'h7;
  localparam logic [3:0] OP_JMP   = 4'h8;
  localparam logic [3:0] OP_HALT  = 4'hF;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_NAND = 2'b10;
  localparam logic [1:0] ALU_NULL = 2'b11;

  state_t     state_q, state_d;
  logic [7:0] pc_q, pc_d;
  logic [7:0] ir_q, ir_d;
  logic       z_q, z_d;

  logic [3:0] opcode;
  logic       is_alu;
  logic       is_imm;
  logic       is_cmp;
  logic [1:0] dec_alu_op;

  assign opcode = ir_q[7:4];
  assign is_alu = (opcode <= OP_NANDI);
  assign is_imm = (opcode >= OP_ADDI) && (opcode <= OP_NANDI);
  assign is_cmp = (opcode == OP_CMP);

  // CMP reuses the SUB encoding so the ALU produces the flag it compares on.
  always_comb begin
    dec_alu_op = ALU_NULL;
    case (opcode)
      OP_ADD,  OP_ADDI:          dec_alu_op = ALU_ADD;
      OP_SUB,  OP_SUBI, OP_CMP:  dec_alu_op = ALU_SUB;
      OP_NAND, OP_NANDI:         dec_alu_op = ALU_NAND;
      default:                   dec_alu_op = ALU_NULL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= 8'h00;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      z_q     <= z_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    z_d     = z_q;
    case (state_q)
      S_FETCH: begin
        if (instr_valid) begin
          ir_d    = instr_in;
          pc_d    = pc_q + 8'd1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        state_d = (opcode == OP_HALT) ? S_HALT : S_EXEC;
      end
      S_EXEC: begin
        if (is_alu || is_cmp) begin
          z_d = zero_in;
        end
        // BZ tests the flag as it stood before this edge, not zero_in.
        if ((opcode == OP_JMP) || ((opcode == OP_BZ) && z_q)) begin
          pc_d = jump_target;
        end
        state_d = is_alu ? S_WB : S_FETCH;
      end
      S_WB: begin
        state_d = S_FETCH;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // Control outputs are forced idle while rst is high so a reset mid-instruction
  // cannot leave a write or ALU op pending on that cycle.
  always_comb begin
    fetch_req = 1'b0;
    rd_addr   = 2'b00;
    rs_addr   = 2'b00;
    alu_op    = ALU_NULL;
    imm_sel   = 1'b0;
    imm2      = 2'b00;
    reg_we    = 1'b0;
    halted    = 1'b0;
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          fetch_req = 1'b1;
        end
        S_DECODE: begin
          rd_addr = ir_q[3:2];
          rs_addr = ir_q[1:0];
        end
        S_EXEC, S_WB: begin
          rd_addr = ir_q[3:2];
          rs_addr = ir_q[1:0];
          if (is_alu || (is_cmp && (state_q == S_EXEC))) begin
            alu_op  = dec_alu_op;
            imm_sel = is_imm;
            imm2    = ir_q[1:0];
          end
          reg_we = (state_q == S_WB);
        end
        S_HALT: begin
          halted = 1'b1;
        end
        default: begin
          fetch_req = 1'b0;
        end
      endcase
    end
  end

  assign pc_out = pc_q;
  assign z_flag = z_q;

endmodule

// File: doc/control_fsm.md
Name: control_fsm

Overview:
- Multi-cycle control unit directly upstream of the 8-bit ALU.
- Fetches one 8-bit instruction per instruction cycle from instruction memory over a valid handshake, then decodes it.
- Drives the ALU's operation select, immediate select, immediate value and register-file read/write controls.
- Owns the PC, the architectural zero flag and the HALT state.

Parameters:
- RESET_PC, 8'h00, PC value loaded on reset.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- instr_in  in  8  instruction byte from instruction memory.
- instr_valid  in  1  instr_in is valid this cycle.
- zero_in  in  1  ALU zero_flag output.
- jump_target  in  8  register-file read data on port 2, i.e. R[rs_addr].
- fetch_req  out  1  request an instruction at pc_out.
- pc_out  out  8  current PC.
- rd_addr  out  2  register-file read port 1 address and write address.
- rs_addr  out  2  register-file read port 2 address.
- alu_op  out  2  00 ADD, 01 SUB, 10 NAND, 11 NULL.
- imm_sel  out  1  1 = ALU uses imm2, 0 = ALU uses src2.
- imm2  out  2  immediate, IR[1:0].
- reg_we  out  1  register-file write enable.
- z_flag  out  1  architectural zero flag.
- halted  out  1  core halted.

Behaviour:
- Instruction format: IR[7:4] opcode, IR[3:2] rd (also src1), IR[1:0] rs or imm2.
- Opcodes:
  - 0000 ADD, 0001 SUB, 0010 NAND: rd <= rd op rs.
  - 0011 ADDI, 0100 SUBI, 0101 NANDI: rd <= rd op zext(imm2).
  - 0110 CMP: SUB rd,rs; flag update only, no writeback.
  - 0111 BZ: if z_flag, pc <= R[rs].
  - 1000 JMP: pc <= R[rs].
  - 1111 HALT.
  - All other opcodes are NOP.
- States: FETCH, DECODE, EXEC, WB, HALT.
- Reset: synchronous; takes priority over every other event in every state, including mid-instruction and HALT. Next-edge values:
  - state = FETCH, pc = RESET_PC, IR = 0, z_flag = 0, halted = 0.
  - All outputs at their idle values: fetch_req 0, reg_we 0, alu_op 11, imm_sel 0, imm2 0, rd_addr 0, rs_addr 0.
- FETCH:
  - fetch_req = 1, pc_out = pc.
  - On a cycle with instr_valid = 1: IR <= instr_in, pc <= pc + 1 (8-bit wrap, FF -> 00), go to DECODE.
  - With instr_valid = 0: stay in FETCH, fetch_req remains 1.
  - instr_valid in any other state is ignored.
- DECODE:
  - rd_addr = IR[3:2], rs_addr = IR[1:0].
  - HALT opcode -> HALT state; all others -> EXEC.
- EXEC:
  - rd_addr and rs_addr held.
  - ALU-class opcodes drive alu_op, imm_sel and imm2 = IR[1:0]. The immediate forms drive imm_sel = 1.
  - At the EXEC edge of an ALU-class opcode or CMP: z_flag <= zero_in.
  - ALU ops -> WB. CMP and NOP -> FETCH.
  - BZ: if z_flag = 1, pc <= jump_target; otherwise pc unchanged. Then -> FETCH.
  - JMP: pc <= jump_target, then -> FETCH.
- WB:
  - reg_we = 1 for exactly one cycle.
  - alu_op, imm_sel, imm2, rd_addr and rs_addr held at their EXEC values so the ALU result stays stable.
  - Next state FETCH.
- Outside EXEC and WB: alu_op = 11 (NULL) and imm_sel = 0, so the ALU flag is never disturbed.
- reg_we is 0 in every state other than WB.
- Latency, excluding fetch wait cycles:
  - ALU ops: 4 cycles (FETCH, DECODE, EXEC, WB).
  - CMP, BZ, JMP, NOP: 3 cycles.
- HALT: halted = 1, fetch_req = 0, every other output idle; left only by rst.
- Boundary cases:
  - BZ uses z_flag as it stood before EXEC.
  - pc wraps FF -> 00 on increment.
  - A jump to the address of the jump itself is legal and loops.

Test Plan:
- Reset then instr_valid held 1 with instr_in = 8'h36 (ADDI R1,2) -> fetch_req 1 at pc 00; DECODE; EXEC with alu_op 00, imm_sel 1, imm2 2'b10, rd_addr 01; WB with reg_we 1 for one cycle; back in FETCH with pc 01; total 4 cycles.
- instr_valid low for 3 cycles in FETCH -> fetch_req stays 1, pc stays, no other output changes; decode starts the cycle after valid rises.
- CMP with zero_in = 1 (instr 8'h65) then BZ with jump_target = 8'h40 (instr 8'h72) -> z_flag 1, reg_we never asserted, pc = 40 at the next FETCH; repeat with zero_in = 0 -> pc = previous pc + 1.
- pc = FF, fetch any NOP (8'hA0) -> pc = 00 after the fetch; alu_op 11 throughout; reg_we 0.
- HALT (8'hF0) -> halted 1, fetch_req 0 indefinitely with instr_valid toggling; rst -> pc = RESET_PC, halted 0, FETCH on the next cycle.
- Assert rst during WB of a SUB -> next cycle reg_we 0, state FETCH, z_flag 0, alu_op 11.
